// File: rtl/sram_mem_controller_pkg.sv
// Shared definitions for the SRAM memory controller.
// Contents:
//   state_t            controller FSM states (IDLE, LO, HI, DONE)
//   BASE_ADDR_DEFAULT  byte address that maps onto SRAM word 0
//   SRAM_DW            SRAM data bus width (one half-word)
package sram_mem_controller_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_t;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;
  localparam int          SRAM_DW           = 16;

endpackage

// File: rtl/sram_mem_controller_if.sv
// MEM-stage memory handshake between the pipeline and the SRAM controller.
// Signals:
//   mem_read, mem_write  level requests, held until ready
//   address, write_data  byte address and store data
//   read_data            load data from the controller
//   ready                0 while a request is still in flight
// Modports: master = pipeline MEM stage, slave = memory controller.
interface sram_mem_controller_if;

  logic        mem_read;
  logic        mem_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output mem_read, mem_write, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  mem_read, mem_write, address, write_data,
    output read_data, ready
  );

endinterface

// File: rtl/sram_mem_controller_phase_counter.sv
// Cycle counter for one half-word phase of an SRAM access.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-low reset
//   clear     restart the count at zero on the next edge
//   count     current cycle index inside the phase
//   terminal  high on the last cycle of the phase (count == WAIT_CYCLES-1)
module sram_mem_controller_phase_counter #(
  parameter int WAIT_CYCLES = 5,
  parameter int WIDTH       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(WAIT_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == LAST);

endmodule

// File: rtl/sram_mem_controller.sv
// Responder for the MEM-stage memory handshake against a 16-bit async SRAM.
// Each 32-bit word moves as two half-word phases (LO, then HI) of
// WAIT_CYCLES cycles each; ready stays low until the word is finished.
// Ports:
//   clk, rst      rising-edge clock, synchronous active-low reset
//   bus           MEM-stage handshake (slave side)
//   sram_addr     SRAM half-word address
//   sram_dq_out   data driven onto the SRAM DQ pins
//   sram_dq_in    data read from the SRAM DQ pins
//   sram_dq_oe    1 = controller drives DQ
//   sram_we_n     active-low SRAM write strobe
module sram_mem_controller
  import sram_mem_controller_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int          WAIT_CYCLES = 5,
  parameter int          SRAM_AW     = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_mem_controller_if.slave  bus,
  output logic [SRAM_AW-1:0]    sram_addr,
  output logic [SRAM_DW-1:0]    sram_dq_out,
  input  logic [SRAM_DW-1:0]    sram_dq_in,
  output logic                  sram_dq_oe,
  output logic                  sram_we_n
);

  localparam int               CW      = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
  localparam int               WORD_W  = SRAM_AW - 1;
  localparam logic [CW-1:0]    PRELAST = CW'(WAIT_CYCLES - 2);

  state_t              state;
  state_t              state_next;
  logic [CW-1:0]       cnt;
  logic                term;
  logic                clear;
  logic                write_q;
  logic [WORD_W-1:0]   word_q;
  logic [31:0]         wdata_q;
  logic [15:0]         rd_lo;
  logic [31:0]         rdata;
  logic [WORD_W-1:0]   live_word;
  logic                op_write;
  logic [WORD_W-1:0]   word_sel;
  logic [31:0]         data_sel;
  logic                entering;
  logic [SRAM_AW-1:0]  addr_d;
  logic [SRAM_DW-1:0]  dq_out_d;
  logic                oe_d;
  logic                we_n_d;

  sram_mem_controller_phase_counter #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .WIDTH       (CW)
  ) u_phase_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .count    (cnt),
    .terminal (term)
  );

  // Out-of-range addresses wrap because the cast keeps only the low word bits.
  assign live_word = WORD_W'((bus.address - BASE_ADDR) >> 2);

  // The counter restarts whenever a phase is entered; outside phases it idles at zero.
  assign clear = ((state != LO) && (state != HI)) || term;

  assign bus.ready     = ~(bus.mem_read | bus.mem_write) | (state == DONE);
  assign bus.read_data = rdata;

  // Next-state logic and next values of the registered SRAM pins. The pins are
  // registered so the async SRAM never sees decode glitches on we_n.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.mem_read | bus.mem_write) state_next = LO;
      LO:      if (term) state_next = HI;
      HI:      if (term) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // While leaving IDLE the latch is not loaded yet, so use the live request.
    op_write = (state == IDLE) ? bus.mem_write  : write_q;
    word_sel = (state == IDLE) ? live_word      : word_q;
    data_sel = (state == IDLE) ? bus.write_data : wdata_q;
    entering = (state_next != state);

    addr_d   = sram_addr;
    dq_out_d = sram_dq_out;
    oe_d     = 1'b0;
    we_n_d   = 1'b1;

    // we_n rises for the last cycle of each phase: the next cycle is the last
    // one when we stay in the phase and the count is one short of terminal.
    if (state_next == LO) begin
      addr_d = {word_sel, 1'b0};
      if (op_write) begin
        oe_d     = 1'b1;
        dq_out_d = data_sel[15:0];
        we_n_d   = !entering && (cnt == PRELAST);
      end
    end else if (state_next == HI) begin
      addr_d = {word_sel, 1'b1};
      if (op_write) begin
        oe_d     = 1'b1;
        dq_out_d = data_sel[31:16];
        we_n_d   = !entering && (cnt == PRELAST);
      end
    end
  end

  // State, request latch, read assembly and registered SRAM pins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      write_q     <= 1'b0;
      word_q      <= '0;
      wdata_q     <= '0;
      rd_lo       <= '0;
      rdata       <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      state       <= state_next;
      sram_addr   <= addr_d;
      sram_dq_out <= dq_out_d;
      sram_dq_oe  <= oe_d;
      sram_we_n   <= we_n_d;
      if (state == IDLE && state_next == LO) begin
        write_q <= bus.mem_write;
        word_q  <= live_word;
        wdata_q <= bus.write_data;
      end
      if (state == LO && term) begin
        rd_lo <= sram_dq_in;
      end
      if (state == HI && term && !write_q) begin
        rdata <= {sram_dq_in, rd_lo};
      end
    end
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Self-checking bench for sram_mem_controller: SRAM pin model with a
// write-commit monitor, half-word reference memory, directed table,
// hand-written corner sequences and randomized transactions.
module tb_sram_mem_controller;

  localparam int          W      = 5;
  localparam int          AW     = 18;
  localparam logic [31:0] BASE   = 32'd1024;
  localparam int          NWORDS = 1 << (AW - 1);
  localparam int          NHALF  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out;
  logic [15:0]   sram_dq_in;
  logic          sram_dq_oe;
  logic          sram_we_n;

  sram_mem_controller_if bus();

  sram_mem_controller #(
    .BASE_ADDR   (BASE),
    .WAIT_CYCLES (W),
    .SRAM_AW     (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_in  (sram_dq_in),
    .sram_dq_oe  (sram_dq_oe),
    .sram_we_n   (sram_we_n)
  );

  always #5 clk = ~clk;

  logic [15:0] sram     [NHALF];
  logic [15:0] ref_sram [NHALF];
  int          checks   = 0;
  int          errors   = 0;
  int          commits  = 0;
  int          glitches = 0;
  logic [31:0] last_read = 32'h0;

  function automatic logic [15:0] init_pattern(input int i);
    return 16'(i * 7 + 3) ^ 16'h5A5A;
  endfunction

  // Index of the low half-word of the word addressed by a byte address.
  function automatic int half_index(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(((off >> 2) % NWORDS) * 2);
  endfunction

  // SRAM model: a write lands when we_n rises, provided address, data and
  // drive were stable across the low pulse and still held at the rise.
  initial begin
    logic          pend;
    logic [AW-1:0] pa;
    logic [15:0]   pd;
    pend = 1'b0;
    pa   = '0;
    pd   = '0;
    for (int i = 0; i < NHALF; i++) sram[i] = init_pattern(i);
    forever begin
      @(negedge clk);
      if (sram_we_n === 1'b0) begin
        if (!pend) begin
          pend = 1'b1;
          pa   = sram_addr;
          pd   = sram_dq_out;
          if (sram_dq_oe !== 1'b1) glitches++;
        end else if (sram_addr !== pa || sram_dq_out !== pd || sram_dq_oe !== 1'b1) begin
          glitches++;
        end
      end else if (pend) begin
        pend = 1'b0;
        if (sram_dq_oe === 1'b1 && sram_addr === pa && sram_dq_out === pd) begin
          sram[pa] = pd;
          commits++;
        end
      end
    end
  end

  assign sram_dq_in = sram[sram_addr];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One full transaction: drive, watch every phase cycle, then compare
  // latency, read data, pin behaviour and SRAM contents against the model.
  task automatic apply_stimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] data, input logic chk, input logic [31:0] exp);
    int          lo_i;
    int          lat;
    int          ctl_bad;
    int          c0;
    int          j;
    logic        hi;
    logic [31:0] seen_rd;
    logic [31:0] exp_rd;
    lo_i    = half_index(addr);
    lat     = -1;
    ctl_bad = 0;
    c0      = commits;
    seen_rd = 32'hxxxxxxxx;
    @(posedge clk);
    #1;
    bus.mem_read   = rd;
    bus.mem_write  = wr;
    bus.address    = addr;
    bus.write_data = data;
    for (int k = 0; k <= 2 * W + 10; k++) begin
      @(negedge clk);
      if (k >= 1 && k <= 2 * W) begin
        j  = (k - 1) % W;
        hi = (k > W);
        if (sram_addr !== AW'(lo_i + int'(hi))) ctl_bad++;
        if (wr) begin
          if (sram_dq_oe !== 1'b1 || sram_we_n !== (j == W - 1) ||
              sram_dq_out !== (hi ? data[31:16] : data[15:0])) ctl_bad++;
        end else if (sram_dq_oe !== 1'b0 || sram_we_n !== 1'b1) begin
          ctl_bad++;
        end
      end
      if (bus.ready === 1'b1) begin
        lat     = k;
        seen_rd = bus.read_data;
        break;
      end
    end
    check_output("latency", 32'(lat), 32'(2 * W + 1));
    if (wr) begin
      exp_rd                 = last_read;
      ref_sram[lo_i]         = data[15:0];
      ref_sram[lo_i + 1]     = data[31:16];
    end else begin
      exp_rd    = {ref_sram[lo_i + 1], ref_sram[lo_i]};
      last_read = exp_rd;
    end
    check_output("read_data", seen_rd, exp_rd);
    if (chk) check_output("table read_data", seen_rd, exp);
    check_output("pin sequence errors", 32'(ctl_bad), 32'd0);
    @(posedge clk);
    #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    check_output("sram commits", 32'(commits - c0), wr ? 32'd2 : 32'd0);
    check_output("sram lo", 32'(sram[lo_i]), 32'(ref_sram[lo_i]));
    check_output("sram hi", 32'(sram[lo_i + 1]), 32'(ref_sram[lo_i + 1]));
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          c0;
    int          bound;
    logic        seen;
    logic [15:0] orig_lo;
    logic [15:0] orig_hi;
    logic [31:0] a;
    logic [31:0] d;
    int          mode;

    for (int i = 0; i < NHALF; i++) ref_sram[i] = init_pattern(i);

    vecs[0] = '{1'b0, 1'b1, 32'd1028,   32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'd1028,   32'h0,        1'b1, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b1, 32'd1024,   32'h12345678, 1'b1, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b0, 32'd1024,   32'h0,        1'b1, 32'h12345678};
    vecs[4] = '{1'b0, 1'b1, 32'd525312, 32'hCAFEF00D, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'd1024,   32'h0,        1'b1, 32'hCAFEF00D};
    vecs[6] = '{1'b1, 1'b0, 32'd525312, 32'h0,        1'b1, 32'hCAFEF00D};

    // Reset held for two cycles with a read pending.
    bus.mem_read   = 1'b1;
    bus.mem_write  = 1'b0;
    bus.address    = 32'd1024;
    bus.write_data = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset read_data", bus.read_data, 32'h0);
    check_output("reset sram_addr", 32'(sram_addr), 32'h0);
    check_output("reset dq_out", 32'(sram_dq_out), 32'h0);
    check_output("reset dq_oe", 32'(sram_dq_oe), 32'h0);
    check_output("reset we_n", 32'(sram_we_n), 32'h1);
    check_output("reset ready", 32'(bus.ready), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check_output("ready after release", 32'(bus.ready), 32'h0);
    seen  = 1'b0;
    bound = 0;
    while (!seen && bound < 4 * W) begin
      @(negedge clk);
      bound++;
      if (bus.ready === 1'b1) seen = 1'b1;
    end
    last_read = {ref_sram[1], ref_sram[0]};
    check_output("first read completes", 32'(seen), 32'h1);
    check_output("first read data", bus.read_data, last_read);
    @(posedge clk);
    #1;
    bus.mem_read = 1'b0;

    // Idle: no requests for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_output("idle pins", {29'h0, bus.ready, sram_we_n, sram_dq_oe}, 32'h6);
    end

    // Directed table: write/read, both asserted, address wrap and alias.
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].chk, vecs[i].exp);
    end
    check_output("sram[2]", 32'(sram[2]), 32'h0000BEEF);
    check_output("sram[3]", 32'(sram[3]), 32'h0000DEAD);

    // Request dropped during LO: the latched write still completes.
    c0 = commits;
    @(posedge clk);
    #1;
    bus.mem_write  = 1'b1;
    bus.address    = 32'd1032;
    bus.write_data = 32'h0BADCAFE;
    repeat (3) @(negedge clk);
    bus.mem_write  = 1'b0;
    bus.write_data = 32'hFFFFFFFF;
    bus.address    = 32'd2048;
    repeat (2 * W + 4) @(negedge clk);
    ref_sram[4] = 16'hCAFE;
    ref_sram[5] = 16'h0BAD;
    check_output("dropped commits", 32'(commits - c0), 32'd2);
    check_output("dropped lo", 32'(sram[4]), 32'h0000CAFE);
    check_output("dropped hi", 32'(sram[5]), 32'h00000BAD);
    apply_stimulus(1'b1, 1'b0, 32'd1032, 32'h0, 1'b1, 32'h0BADCAFE);

    // Reset during the third LO cycle of a write aborts it.
    c0      = commits;
    orig_lo = ref_sram[8];
    orig_hi = ref_sram[9];
    @(posedge clk);
    #1;
    bus.mem_write  = 1'b1;
    bus.address    = 32'd1040;
    bus.write_data = 32'hA1B2C3D4;
    repeat (4) @(negedge clk);
    rst           = 1'b0;
    bus.mem_write = 1'b0;
    @(negedge clk);
    check_output("abort we_n", 32'(sram_we_n), 32'h1);
    check_output("abort dq_oe", 32'(sram_dq_oe), 32'h0);
    check_output("abort sram_addr", 32'(sram_addr), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check_output("abort commits", 32'(commits - c0), 32'd0);
    check_output("abort sram hi", 32'(sram[9]), 32'(orig_hi));
    check_output("abort sram lo", 32'(sram[8]), 32'(orig_lo));
    apply_stimulus(1'b1, 1'b0, 32'd1040, 32'h0, 1'b0, 32'h0);

    // Randomized traffic against the reference memory.
    for (int i = 0; i < 40; i++) begin
      mode = int'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      d = $urandom;
      apply_stimulus(mode != 1, mode != 0, a, d, 1'b0, 32'h0);
    end

    check_output("we_n pulse stability", 32'(glitches), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
